matmul_operand_feeder: RTL and testbench
========================================

# matmul_operand_feeder

Host-side initiator for the matrix-multiply controller. It collects eight operand pairs from a host valid/ready stream into a local buffer, then issues a `start` pulse to the controller. While the controller holds `load_matrix`, it streams the pairs out with a matching `entry_count`, then waits for the controller's `done` before accepting the next batch. It sits between the host interface and the controller/datapath, and owns the controller's `start` and `entry_count` inputs.

## Interface
- `DATA_W`, 8, width of each operand
- `ENTRIES`, 8, operand pairs per batch; the controller's last index is `ENTRIES-1` = 7
- `CNT_W`, 4, width of `entry_count`
- `TIMEOUT`, 16, maximum cycles spent waiting for `load_matrix` or `done`
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_valid`  in  1  host operand pair valid
- `in_ready`  out  1  feeder accepts a pair; a transfer occurs when `in_valid && in_ready` at the edge
- `in_a`, `in_b`  in  `DATA_W`  host operand pair
- `start`  out  1  one-cycle pulse to the controller
- `load_matrix`  in  1  from the controller; high while it is in the Multiply state
- `done`  in  1  from the controller; high while it is in the Store state
- `entry_count`  out  `CNT_W`  index of the pair currently presented
- `op_a`, `op_b`  out  `DATA_W`  operand pair at `buf[entry_count]`
- `op_valid`  out  1  `op_a`/`op_b` are meaningful (STREAM state and `load_matrix` high)
- `busy`  out  1  high in any state other than FILL
- `batch_done`  out  1  one-cycle pulse when a batch completes
- `err`  out  1  sticky protocol/timeout flag; cleared only by `reset`

## Operation
- States: FILL, ISSUE, WAIT_LOAD, STREAM, WAIT_DONE.
- **FILL:** `in_ready`=1.
  - Each accepted pair writes `buf[wr_ptr]` and increments `wr_ptr`.
  - When the pair at `wr_ptr`=7 is accepted, `wr_ptr` wraps to 0 and the state moves to ISSUE.
- **ISSUE:** `start`=1 for exactly this one cycle; next state is WAIT_LOAD. The wait timer is cleared.
- **WAIT_LOAD:** wait for `load_matrix`=1, with `entry_count`=0.
  - On the first `load_matrix`=1 cycle the state moves to STREAM. `entry_count` stays 0, so index 0 is presented on that edge's next cycle.
  - If the timer reaches `TIMEOUT` first: set `err`, go to FILL.
- **STREAM:**
  - `op_a`/`op_b` = `buf[entry_count]` (combinational read of registered index).
  - At each edge with `load_matrix`=1 and `entry_count`<7: `entry_count` increments.
  - At the edge with `load_matrix`=1 and `entry_count`=7: `entry_count` goes to 0 and the state moves to WAIT_DONE. The controller leaves Multiply on the same edge.
  - `load_matrix`=0 while in STREAM is a protocol error: set `err`, clear `entry_count` and `wr_ptr`, go to FILL.
- **WAIT_DONE:**
  - On `done`=1: pulse `batch_done` for one cycle (registered, asserted the cycle after `done` is seen), then go to FILL.
  - Timeout behaves as in WAIT_LOAD.
- Arithmetic:
  - `entry_count` and `wr_ptr` never exceed 7; no modular overflow is possible.
  - The timer saturates at `TIMEOUT`.
- The buffer holds no data across error recovery; a new batch must be refilled from index 0.
- `in_valid` is ignored outside FILL. The host must hold its pair until `in_ready`.

## Timing
- Reset values:
  - state=FILL
  - `in_ready`=1 once reset is released (0 while `reset` is high)
  - `start`, `op_valid`, `busy`, `batch_done`, `err` = 0
  - `entry_count`=0, `wr_ptr`=0
  - `op_a`/`op_b` = buffer contents, which are don't-care
- Reset asserted mid-batch: immediate return to FILL; `start` is never left high.
- Nominal batch with the controller:
  - 8 fill cycles
  - ISSUE, 1 cycle
  - WAIT_LOAD, 1 cycle (the controller samples `start` at the ISSUE edge)
  - STREAM, 8 cycles
  - WAIT_DONE: 1 cycle of Accumulate, then `done` during Store
  - `batch_done` follows 1 cycle later
- Total: 21 cycles from the first accepted pair to `batch_done`.
- Simultaneous `done` and timeout expiry: `done` wins.

## Structure
- Shared package holds:
  - the state encoding (5 states, 3 bits)
  - `ENTRIES`, `CNT_W`
  - the last-index constant 7, shared with the controller's `entry_count` compare
- One sub-module: `operand_buffer`, an 8×(2·`DATA_W`) register file with one write port and one combinational read port. It has no reset on its data.

## Test plan
- **Nominal batch:** push pairs (1,2)…(8,9) back-to-back against the real controller.
  - `start` is high for exactly 1 cycle.
  - `entry_count` is 0..7 on consecutive `load_matrix` cycles, with `op_a`=1..8.
  - `batch_done` arrives 21 cycles after the first transfer; `err`=0.
- **Host stalls:** `in_valid` toggles 1,0,1,0…
  - Buffer order is preserved; ISSUE only after the 8th transfer.
  - `in_ready`=0 from ISSUE until after `batch_done`.
- **Load timeout:** stub controller never raises `load_matrix`.
  - `err`=1 exactly 16 cycles after ISSUE; state returns to FILL; `in_ready`=1.
- **Protocol error:** stub drops `load_matrix` at `entry_count`=3.
  - `err`=1, `entry_count`=0, FILL next cycle; no `batch_done`.
- **Reset mid-STREAM:** assert `reset` at `entry_count`=5.
  - All outputs take their reset values asynchronously, before the next edge.
  - A subsequent nominal batch completes correctly.
- **Done/timeout coincidence:** stub raises `done` on the cycle the timer hits 16.
  - `batch_done`=1 and `err`=0.

Source files
------------

// File: rtl/matmul_operand_feeder_pkg.sv
// Shared constants and state encoding for the operand feeder and its controller.
// Pure declarations: no latency, no backpressure.
package matmul_operand_feeder_pkg;

    localparam int ENTRIES  = 8;
    localparam int CNT_W    = 4;
    localparam int ADDR_W   = $clog2(ENTRIES);
    localparam int LAST_IDX = ENTRIES - 1;

    // Same last-index value the controller compares entry_count against.
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LAST_IDX);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LAST_IDX);

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOAD = 3'd2,
        STREAM    = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_operand_feeder_if.sv
// Host stream plus controller handshake bundle for the operand feeder.
// Wires only: no latency; host side uses valid/ready, controller side uses level handshakes.
interface matmul_operand_feeder_if
    import matmul_operand_feeder_pkg::*;
    #(parameter int DATA_W = 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              start;
    logic              load_matrix;
    logic              done;
    logic [CNT_W-1:0]  entry_count;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              busy;
    logic              batch_done;
    logic              err;

    modport master (
        input  in_valid, in_a, in_b, load_matrix, done,
        output in_ready, start, entry_count, op_a, op_b, op_valid, busy, batch_done, err
    );

    modport slave (
        output in_valid, in_a, in_b, load_matrix, done,
        input  in_ready, start, entry_count, op_a, op_b, op_valid, busy, batch_done, err
    );

endinterface

// File: rtl/matmul_operand_feeder_buffer.sv
// operand_buffer: ENTRIES x (2*DATA_W) register file, one write port, combinational read.
// Write lands on the clock edge, read is zero-latency; no backpressure, no data reset.
module operand_buffer
    import matmul_operand_feeder_pkg::*;
    #(parameter int DATA_W = 8) (
    input  logic                clock,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [2*DATA_W-1:0] rd_dat
);

    logic [2*DATA_W-1:0] mem [ENTRIES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/matmul_operand_feeder.sv
// Collects ENTRIES operand pairs, starts the controller, streams pairs during load_matrix.
// 21 cycles first transfer to batch_done nominally; in_ready drops for the whole batch after fill.
module matmul_operand_feeder
    import matmul_operand_feeder_pkg::*;
    #(parameter int DATA_W  = 8,
      parameter int TIMEOUT = 16) (
    input  logic                     clock,
    input  logic                     reset,
    matmul_operand_feeder_if.master  bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  wr_ptr, wr_ptr_nx;
    logic [CNT_W-1:0]   entry_count, cnt_nx;
    logic [TMR_W-1:0]   timer, timer_nx, timer_inc;
    logic               err, err_nx;
    logic               batch_done, bdone_nx;
    logic               start, op_valid, in_ready, wr_en, timer_hit;
    logic [2*DATA_W-1:0] rd_dat;

    assign in_ready  = (state == FILL) && !reset;
    assign wr_en     = bus.in_valid && in_ready;
    assign timer_inc = (timer == TMR_W'(TIMEOUT)) ? timer : timer + 1'b1;
    // Timer is zero during ISSUE / first WAIT_DONE cycle; this edge makes it reach TIMEOUT.
    assign timer_hit = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            wr_ptr      <= '0;
            entry_count <= '0;
            timer       <= '0;
            err         <= 1'b0;
            batch_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr_nx;
            entry_count <= cnt_nx;
            timer       <= timer_nx;
            err         <= err_nx;
            batch_done  <= bdone_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        cnt_nx    = entry_count;
        timer_nx  = timer;
        err_nx    = err;
        bdone_nx  = 1'b0;
        start     = 1'b0;
        op_valid  = 1'b0;
        case (state)
            FILL: begin
                if (wr_en) begin
                    if (wr_ptr == LAST_PTR) begin
                        wr_ptr_nx = '0;
                        timer_nx  = '0;
                        state_nx  = ISSUE;
                    end else begin
                        wr_ptr_nx = wr_ptr + 1'b1;
                    end
                end
            end
            ISSUE: begin
                start    = 1'b1;
                timer_nx = timer_inc;
                state_nx = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                cnt_nx   = '0;
                timer_nx = timer_inc;
                if (bus.load_matrix) begin
                    state_nx = STREAM;
                end else if (timer_hit) begin
                    err_nx   = 1'b1;
                    state_nx = FILL;
                end
            end
            STREAM: begin
                op_valid = bus.load_matrix;
                if (!bus.load_matrix) begin
                    err_nx    = 1'b1;
                    cnt_nx    = '0;
                    wr_ptr_nx = '0;
                    state_nx  = FILL;
                end else if (entry_count == LAST_CNT) begin
                    cnt_nx   = '0;
                    timer_nx = '0;
                    state_nx = WAIT_DONE;
                end else begin
                    cnt_nx = entry_count + 1'b1;
                end
            end
            WAIT_DONE: begin
                timer_nx = timer_inc;
                // done takes priority over a coincident timeout
                if (bus.done) begin
                    bdone_nx = 1'b1;
                    state_nx = FILL;
                end else if (timer_hit) begin
                    err_nx   = 1'b1;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    operand_buffer #(.DATA_W(DATA_W)) u_buf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_dat  ({bus.in_a, bus.in_b}),
        .rd_addr (entry_count[ADDR_W-1:0]),
        .rd_dat  (rd_dat)
    );

    assign bus.in_ready    = in_ready;
    assign bus.start       = start;
    assign bus.entry_count = entry_count;
    assign bus.op_a        = rd_dat[2*DATA_W-1:DATA_W];
    assign bus.op_b        = rd_dat[DATA_W-1:0];
    assign bus.op_valid    = op_valid;
    assign bus.busy        = (state != FILL);
    assign bus.batch_done  = batch_done;
    assign bus.err         = err;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Directed bench for matmul_operand_feeder; the bench itself plays the host and the controller.
module tb_matmul_operand_feeder;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   t0     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc_n <= cyc_n + 1;

    matmul_operand_feeder_if #(.DATA_W(8)) bus ();

    matmul_operand_feeder #(.DATA_W(8), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        settle();
    endtask

    // Pushes pairs (base+i, base+i+1); with stall an idle cycle follows each transfer but the last.
    task automatic fill_batch(input logic [7:0] base, input bit stall);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = base + 8'(i);
            bus.in_b     = base + 8'(i + 1);
            settle();
            if (i == 0) t0 = cyc_n;
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            nxt();
            if (stall && i < 7) begin
                bus.in_valid = 1'b0;
                bus.in_a     = 8'hEE;
                bus.in_b     = 8'hEE;
                settle();
                chk("stall_no_start", 32'(bus.start), 32'd0);
                chk("stall_in_ready", 32'(bus.in_ready), 32'd1);
                nxt();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // From the ISSUE cycle through a full stream; ends in the first WAIT_DONE cycle.
    task automatic stream_phase(input logic [7:0] base);
        settle();
        chk("issue_start", 32'(bus.start), 32'd1);
        chk("issue_in_ready", 32'(bus.in_ready), 32'd0);
        chk("issue_busy", 32'(bus.busy), 32'd1);
        nxt();
        bus.load_matrix = 1'b1;
        settle();
        chk("start_one_cycle", 32'(bus.start), 32'd0);
        chk("wait_load_cnt", 32'(bus.entry_count), 32'd0);
        chk("wait_load_op_valid", 32'(bus.op_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            nxt();
            settle();
            chk("stream_cnt", 32'(bus.entry_count), 32'(i));
            chk("stream_op_a", 32'(bus.op_a), 32'(base) + 32'(i));
            chk("stream_op_b", 32'(bus.op_b), 32'(base) + 32'(i + 1));
            chk("stream_op_valid", 32'(bus.op_valid), 32'd1);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd0);
        end
        nxt();
        bus.load_matrix = 1'b0;
        settle();
        chk("wait_done_cnt", 32'(bus.entry_count), 32'd0);
        chk("wait_done_busy", 32'(bus.busy), 32'd1);
        chk("wait_done_op_valid", 32'(bus.op_valid), 32'd0);
    endtask

    // Controller Accumulate cycle, then Store with done; lat is cycles from first transfer cycle.
    task automatic nominal_tail(input int lat);
        nxt();
        bus.done = 1'b1;
        settle();
        chk("store_no_bdone_yet", 32'(bus.batch_done), 32'd0);
        chk("store_in_ready", 32'(bus.in_ready), 32'd0);
        nxt();
        bus.done = 1'b0;
        settle();
        chk("batch_done", 32'(bus.batch_done), 32'd1);
        chk("batch_latency", 32'(cyc_n - t0), 32'(lat));
        chk("batch_err", 32'(bus.err), 32'd0);
        chk("after_batch_in_ready", 32'(bus.in_ready), 32'd1);
        nxt();
        settle();
        chk("batch_done_pulse", 32'(bus.batch_done), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.load_matrix = 1'b0;
        bus.done        = 1'b0;

        // Reset values
        nxt();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_cnt", 32'(bus.entry_count), 32'd0);
        chk("rst_bdone", 32'(bus.batch_done), 32'd0);
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        nxt();
        reset = 1'b0;
        settle();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        nxt();

        // Nominal batch: (1,2)..(8,9); batch_done is the 21st cycle counting the first transfer cycle
        fill_batch(8'd1, 1'b0);
        stream_phase(8'd1);
        nominal_tail(20);

        // Host stalls: 7 idle cycles inserted
        fill_batch(8'h10, 1'b1);
        stream_phase(8'h10);
        nominal_tail(27);

        // Load timeout: load_matrix never rises
        fill_batch(8'h20, 1'b0);
        settle();
        chk("to_issue_start", 32'(bus.start), 32'd1);
        repeat (15) nxt();
        chk("to_err_before", 32'(bus.err), 32'd0);
        chk("to_still_waiting", 32'(bus.busy), 32'd1);
        nxt();
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_fill_busy", 32'(bus.busy), 32'd0);
        chk("to_in_ready", 32'(bus.in_ready), 32'd1);
        nxt();
        chk("to_err_sticky", 32'(bus.err), 32'd1);

        // Protocol error: load_matrix drops at entry_count 3
        do_reset();
        chk("pe_err_cleared", 32'(bus.err), 32'd0);
        nxt();
        fill_batch(8'h30, 1'b0);
        nxt();
        bus.load_matrix = 1'b1;
        repeat (4) nxt();
        bus.load_matrix = 1'b0;
        settle();
        chk("pe_cnt3", 32'(bus.entry_count), 32'd3);
        chk("pe_op_a", 32'(bus.op_a), 32'h33);
        chk("pe_op_valid", 32'(bus.op_valid), 32'd0);
        nxt();
        chk("pe_err", 32'(bus.err), 32'd1);
        chk("pe_cnt0", 32'(bus.entry_count), 32'd0);
        chk("pe_fill", 32'(bus.busy), 32'd0);
        chk("pe_in_ready", 32'(bus.in_ready), 32'd1);
        chk("pe_no_bdone", 32'(bus.batch_done), 32'd0);
        nxt();
        chk("pe_no_bdone_later", 32'(bus.batch_done), 32'd0);

        // Reset mid-STREAM at entry_count 5, outputs checked before the next edge
        do_reset();
        nxt();
        fill_batch(8'h40, 1'b0);
        nxt();
        bus.load_matrix = 1'b1;
        repeat (6) nxt();
        settle();
        chk("mr_cnt5", 32'(bus.entry_count), 32'd5);
        chk("mr_op_a", 32'(bus.op_a), 32'h45);
        reset = 1'b1;
        #1;
        chk("mr_cnt", 32'(bus.entry_count), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mr_start", 32'(bus.start), 32'd0);
        chk("mr_op_valid", 32'(bus.op_valid), 32'd0);
        chk("mr_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        bus.load_matrix = 1'b0;
        nxt();
        fill_batch(8'h50, 1'b0);
        stream_phase(8'h50);
        nominal_tail(20);

        // done arrives on the cycle the WAIT_DONE timer would expire
        fill_batch(8'h60, 1'b0);
        stream_phase(8'h60);
        repeat (15) nxt();
        chk("co_err_before", 32'(bus.err), 32'd0);
        chk("co_busy", 32'(bus.busy), 32'd1);
        bus.done = 1'b1;
        nxt();
        bus.done = 1'b0;
        settle();
        chk("co_batch_done", 32'(bus.batch_done), 32'd1);
        chk("co_err", 32'(bus.err), 32'd0);
        chk("co_fill", 32'(bus.busy), 32'd0);
        nxt();
        chk("co_err_after", 32'(bus.err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
